// File: rtl/fu_issue_arbiter_pkg.sv
// Shared defaults, the issue packet layout and small helpers for the FU issue arbiter.
package fu_issue_arbiter_pkg;

    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_INST_ID_BITS = 6;
    localparam int DEF_PRN_BITS     = 6;
    localparam int DEF_MAX_OPERANDS = 3;
    localparam int DEF_MAX_INFLIGHT = 4;

    // Packet layout at the default widths; the top builds the same shape from its own parameters.
    typedef struct packed {
        logic [DEF_INST_ID_BITS-1:0]                       inst_id;
        logic [31:0]                                       inst;
        logic [DEF_MAX_OPERANDS-1:0][63:0]                 op;
        logic [DEF_MAX_OPERANDS-1:0][DEF_PRN_BITS-1:0]     out_prn;
        logic [63:0]                                       pc;
    } issue_pkt_t;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fu_issue_arbiter_if.sv
// Requester lanes and FU-facing lane of the issue arbiter, bundled for port lists.
interface fu_issue_arbiter_if #(
    parameter int NUM_REQ      = 4,
    parameter int INST_ID_BITS = 6,
    parameter int PRN_BITS     = 6,
    parameter int MAX_OPERANDS = 3
);

    logic [NUM_REQ-1:0]                                   req_valid;
    logic [NUM_REQ-1:0][INST_ID_BITS-1:0]                 req_inst_id;
    logic [NUM_REQ-1:0][31:0]                             req_inst;
    logic [NUM_REQ-1:0][MAX_OPERANDS-1:0][63:0]           req_op;
    logic [NUM_REQ-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0]   req_out_prn;
    logic [NUM_REQ-1:0][63:0]                             req_pc;
    logic [NUM_REQ-1:0]                                   req_grant;

    logic                                                 fu_inst_valid;
    logic [INST_ID_BITS-1:0]                              fu_inst_id;
    logic [31:0]                                          fu_inst;
    logic [MAX_OPERANDS-1:0][63:0]                        fu_op;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]                fu_out_prn;
    logic [63:0]                                          fu_pc;
    logic                                                 fu_ready;
    logic                                                 fu_out_valid;

    // master: the RS array plus FU environment; slave: the arbiter itself
    modport master (
        output req_valid, req_inst_id, req_inst, req_op, req_out_prn, req_pc,
        output fu_ready, fu_out_valid,
        input  req_grant,
        input  fu_inst_valid, fu_inst_id, fu_inst, fu_op, fu_out_prn, fu_pc
    );

    modport slave (
        input  req_valid, req_inst_id, req_inst, req_op, req_out_prn, req_pc,
        input  fu_ready, fu_out_valid,
        output req_grant,
        output fu_inst_valid, fu_inst_id, fu_inst, fu_op, fu_out_prn, fu_pc
    );

endinterface

// File: rtl/fu_issue_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping at N.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    always_comb begin : select
        int   idx;
        logic found;
        // NOTE: every combinational output gets a default before any branch, so no latch can form.
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (en && !found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/fu_issue_arbiter.sv
// Shares one functional unit between NUM_REQ reservation stations: round-robin pick,
// one-entry holding register toward the FU, and an in-flight credit counter.
module fu_issue_arbiter
    import fu_issue_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int INST_ID_BITS = DEF_INST_ID_BITS,
    parameter int PRN_BITS     = DEF_PRN_BITS,
    parameter int MAX_OPERANDS = DEF_MAX_OPERANDS,
    parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    fu_issue_arbiter_if.slave                   bus,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]   inflight,
    output logic                                idle,
    output logic                                err_underflow
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_INFLIGHT + 1);

    // Same shape as issue_pkt_t, sized by this instance's parameters.
    typedef struct packed {
        logic [INST_ID_BITS-1:0]                   inst_id;
        logic [31:0]                               inst;
        logic [MAX_OPERANDS-1:0][63:0]             op;
        logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]     out_prn;
        logic [63:0]                               pc;
    } pkt_t;

    pkt_t          req_pkt [NUM_REQ];
    pkt_t          sel_pkt;
    pkt_t          held_pkt;
    logic          held_valid;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] rr_next;
    logic [NUM_REQ-1:0] gnt;

    logic xfer;
    logic load_en;
    logic credit_ok;
    logic grant_en;
    logic cnt_inc;
    logic cnt_dec;

    for (genvar r = 0; r < NUM_REQ; r++) begin : g_lane
        assign req_pkt[r].inst_id = bus.req_inst_id[r];
        assign req_pkt[r].inst    = bus.req_inst[r];
        assign req_pkt[r].op      = bus.req_op[r];
        assign req_pkt[r].out_prn = bus.req_out_prn[r];
        assign req_pkt[r].pc      = bus.req_pc[r];
    end

    assign xfer    = held_valid && bus.fu_ready;
    assign load_en = !held_valid || xfer;

    // Compared as inflight + xfer < MAX + done so a completion at zero cannot wrap the sum.
    assign credit_ok = ({1'b0, inflight} + (CW+1)'(xfer))
                     < ((CW+1)'(MAX_INFLIGHT) + (CW+1)'(bus.fu_out_valid));

    assign grant_en = !rst && !flush && load_en && credit_ok && (|bus.req_valid);

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req     (bus.req_valid),
        .ptr     (rr_ptr),
        .en      (grant_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign sel_pkt = req_pkt[gnt_idx];
    assign rr_next = IW'(wrap_inc(int'(gnt_idx), NUM_REQ));

    // A transfer killed by flush never reaches the FU, so it earns no credit.
    assign cnt_inc = xfer && !flush;
    assign cnt_dec = bus.fu_out_valid;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            held_valid    <= 1'b0;
            held_pkt      <= '0;
            rr_ptr        <= '0;
            inflight      <= '0;
            err_underflow <= 1'b0;
        end else begin
            if (flush) begin
                held_valid <= 1'b0;
            end else if (grant_en) begin
                held_valid <= 1'b1;
                held_pkt   <= sel_pkt;
                rr_ptr     <= rr_next;
            end else if (xfer) begin
                held_valid <= 1'b0;
            end

            if (cnt_dec && inflight == '0) begin
                err_underflow <= 1'b1;
            end

            if (cnt_inc && !cnt_dec) begin
                inflight <= inflight + CW'(1);
            end else if (!cnt_inc && cnt_dec && inflight != '0) begin
                inflight <= inflight - CW'(1);
            end
        end
    end

    assign bus.req_grant     = gnt;
    assign bus.fu_inst_valid = held_valid;
    assign bus.fu_inst_id    = held_pkt.inst_id;
    assign bus.fu_inst       = held_pkt.inst;
    assign bus.fu_op         = held_pkt.op;
    assign bus.fu_out_prn    = held_pkt.out_prn;
    assign bus.fu_pc         = held_pkt.pc;

    assign idle = (inflight == '0) && !held_valid;

endmodule

// File: tb/tb_fu_issue_arbiter.sv
// Bench for fu_issue_arbiter: directed scenarios plus random traffic against a cycle-level model.
module tb_fu_issue_arbiter;
    import fu_issue_arbiter_pkg::*;

    localparam int N    = 4;
    localparam int MAXI = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [1:0] inflight;
    logic       idle;
    logic       err_underflow;

    int total = 0;
    int bad   = 0;

    fu_issue_arbiter_if #(.NUM_REQ(N)) bus ();

    fu_issue_arbiter #(.NUM_REQ(N), .MAX_INFLIGHT(MAXI)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .bus           (bus),
        .inflight      (inflight),
        .idle          (idle),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    // Reference model state
    issue_pkt_t     cur [N];
    issue_pkt_t     m_held;
    bit             m_valid;
    bit             m_err;
    bit             m_last_xfer;
    int             m_rr;
    int             m_inflight;
    logic [N-1:0]   obs_gnt;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic randomize_reqs();
        for (int r = 0; r < N; r++) begin
            cur[r].inst_id = 6'($urandom);
            cur[r].inst    = $urandom;
            for (int o = 0; o < DEF_MAX_OPERANDS; o++) begin
                cur[r].op[o]      = {$urandom, $urandom};
                cur[r].out_prn[o] = 6'($urandom);
            end
            cur[r].pc = {$urandom, $urandom};
        end
    endtask

    // One cycle: drive at negedge, check the grant, advance the model at posedge, check registers.
    task automatic step(input logic [N-1:0] v, input logic rdy, input logic done,
                        input logic fl, input logic rs);
        bit           xfer;
        bit           credit;
        bit           gen;
        int           win;
        logic [N-1:0] exp_gnt;
        rst              = rs;
        flush            = fl;
        bus.req_valid    = v;
        bus.fu_ready     = rdy;
        bus.fu_out_valid = done;
        for (int r = 0; r < N; r++) begin
            bus.req_inst_id[r] = cur[r].inst_id;
            bus.req_inst[r]    = cur[r].inst;
            bus.req_op[r]      = cur[r].op;
            bus.req_out_prn[r] = cur[r].out_prn;
            bus.req_pc[r]      = cur[r].pc;
        end
        #1;
        xfer   = m_valid && rdy;
        credit = (m_inflight + int'(xfer) - int'(done)) < MAXI;
        gen    = !rs && !fl && (!m_valid || xfer) && credit && (v != '0);
        win    = -1;
        if (gen) begin
            for (int k = 0; k < N; k++) begin
                int r;
                r = (m_rr + k) % N;
                if (win < 0 && v[r]) win = r;
            end
        end
        exp_gnt = '0;
        if (win >= 0) exp_gnt[win] = 1'b1;
        obs_gnt = bus.req_grant;
        check("req_grant", obs_gnt, exp_gnt);

        @(posedge clk);
        if (rs) begin
            m_valid     = 0;
            m_held      = '0;
            m_inflight  = 0;
            m_err       = 0;
            m_rr        = 0;
            m_last_xfer = 0;
        end else begin
            if (done && m_inflight == 0) m_err = 1;
            m_inflight = m_inflight + ((xfer && !fl) ? 1 : 0) - (done ? 1 : 0);
            if (m_inflight < 0) m_inflight = 0;
            m_last_xfer = xfer && !fl;
            if (fl) m_valid = 0;
            else if (win >= 0) begin
                m_valid = 1;
                m_held  = cur[win];
                m_rr    = (win + 1) % N;
            end else if (xfer) m_valid = 0;
        end

        @(negedge clk);
        check("fu_inst_valid", bus.fu_inst_valid, m_valid);
        check("fu_inst_id", bus.fu_inst_id, m_held.inst_id);
        check("fu_inst", bus.fu_inst, m_held.inst);
        check("fu_op", bus.fu_op, m_held.op);
        check("fu_out_prn", bus.fu_out_prn, m_held.out_prn);
        check("fu_pc", bus.fu_pc, m_held.pc);
        check("inflight", inflight, m_inflight);
        check("idle", idle, (m_inflight == 0) && !m_valid);
        check("err_underflow", err_underflow, m_err);
    endtask

    task automatic drain();
        repeat (5) step('0, 1'b1, m_inflight > 0, 1'b0, 1'b0);
        check("drain_idle", idle, 1'b1);
    endtask

    initial begin
        int           gcount;
        logic [5:0]   exp_id;
        logic [N-1:0] rv;
        logic         rdy;
        logic         done;
        logic         fl;
        logic         rs;

        rst              = 1'b1;
        flush            = 1'b0;
        bus.req_valid    = '0;
        bus.fu_ready     = 1'b0;
        bus.fu_out_valid = 1'b0;
        randomize_reqs();
        @(negedge clk);

        // Reset state
        step('0, 1'b0, 1'b0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_valid", bus.fu_inst_valid, 1'b0);
        check("rst_inflight", inflight, 2'd0);
        check("rst_idle", idle, 1'b1);

        // Rotation with all requesters valid
        for (int k = 0; k < 5; k++) begin
            randomize_reqs();
            exp_id = cur[k % N].inst_id;
            step(4'hF, 1'b1, m_last_xfer, 1'b0, 1'b0);
            check("rot_gnt", obs_gnt, 4'b0001 << (k % N));
            check("rot_id", bus.fu_inst_id, exp_id);
        end
        drain();

        // Backpressure on a packet from requester 2
        randomize_reqs();
        cur[2].inst_id = 6'h15;
        step(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
        check("bp_gnt", obs_gnt, 4'b0100);
        repeat (3) begin
            randomize_reqs();
            step(4'b1011, 1'b0, 1'b0, 1'b0, 1'b0);
            check("bp_hold_gnt", obs_gnt, 4'b0000);
            check("bp_hold_valid", bus.fu_inst_valid, 1'b1);
            check("bp_hold_id", bus.fu_inst_id, 6'h15);
        end
        randomize_reqs();
        step(4'b1011, 1'b1, 1'b0, 1'b0, 1'b0);
        check("bp_release_gnt", obs_gnt, 4'b1000);
        check("bp_release_inflight", inflight, 2'd1);
        drain();

        // Credit limit with no completions
        gcount = 0;
        for (int c = 0; c < 5; c++) begin
            randomize_reqs();
            step(4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
            if (obs_gnt != '0) gcount++;
        end
        check("cr_grants", gcount, 2);
        check("cr_inflight", inflight, 2'd2);
        check("cr_valid", bus.fu_inst_valid, 1'b0);
        randomize_reqs();
        step(4'hF, 1'b1, 1'b1, 1'b0, 1'b0);
        check("cr_release_gnt", |obs_gnt, 1'b1);
        check("cr_release_inflight", inflight, 2'd1);
        drain();

        // Transfer and completion in the same cycle
        randomize_reqs();
        step(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
        randomize_reqs();
        step(4'b0010, 1'b1, 1'b0, 1'b0, 1'b0);
        check("sim_pre_inflight", inflight, 2'd1);
        randomize_reqs();
        step(4'b0100, 1'b1, 1'b1, 1'b0, 1'b0);
        check("sim_gnt", obs_gnt, 4'b0100);
        check("sim_inflight", inflight, 2'd1);
        drain();

        // Flush of a held packet while the FU is ready
        randomize_reqs();
        cur[0].inst_id = 6'h01;
        step(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
        randomize_reqs();
        cur[1].inst_id = 6'h07;
        step(4'b0010, 1'b1, 1'b0, 1'b0, 1'b0);
        check("fl_pre_id", bus.fu_inst_id, 6'h07);
        randomize_reqs();
        step(4'hF, 1'b1, 1'b0, 1'b1, 1'b0);
        check("fl_gnt", obs_gnt, 4'b0000);
        check("fl_valid", bus.fu_inst_valid, 1'b0);
        check("fl_inflight", inflight, 2'd1);
        check("fl_id_held", bus.fu_inst_id, 6'h07);
        randomize_reqs();
        step(4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
        check("fl_rr_kept", obs_gnt, 4'b0100);
        drain();

        // Underflow, then reset in the middle of traffic
        step('0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("uf_err", err_underflow, 1'b1);
        check("uf_inflight", inflight, 2'd0);
        randomize_reqs();
        step(4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        randomize_reqs();
        step(4'hF, 1'b1, 1'b0, 1'b0, 1'b1);
        check("rs_gnt", obs_gnt, 4'b0000);
        check("rs_valid", bus.fu_inst_valid, 1'b0);
        check("rs_err", err_underflow, 1'b0);
        check("rs_pc", bus.fu_pc, 64'd0);
        randomize_reqs();
        step(4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rs_first_gnt", obs_gnt, 4'b0010);

        // Random traffic
        repeat (400) begin
            randomize_reqs();
            rv   = N'($urandom);
            rdy  = ($urandom_range(0, 3) != 0);
            done = (m_inflight > 0) && ($urandom_range(0, 2) == 0);
            fl   = ($urandom_range(0, 15) == 0);
            rs   = ($urandom_range(0, 63) == 0);
            step(rv, rdy, done, fl, rs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
